// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives a synchronous-read instruction
// memory. It also loads the IF/ID pipeline register, holds it through hazard
// stalls and squashes the wrong-path slot on a branch/jump redirect.
//
// Handshake: there is no valid/ready pair here. stall=1 means "IF/ID is not
// consumed this cycle". redirect_valid=1 is a one-cycle command that wins over
// stall. if_id_valid qualifies if_id_inst/if_id_pc_plus1.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_inst,
    output logic [DATA_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    // pc_q: next address to fetch; fetch_pc_q: address whose data is on mem_inst.
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] if_id_inst_q, if_id_inst_d;
    logic [ADDR_W-1:0] if_id_pc_plus1_q, if_id_pc_plus1_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [31:0]       stall_count_q, stall_count_d;

    // Memory address: a stall replays fetch_pc_q so mem_inst stays stable.
    always_comb begin
        if (reset) begin
            mem_addr = RST_PC;
        end else if (redirect_valid) begin
            mem_addr = redirect_pc;
        end else if (stall) begin
            mem_addr = fetch_pc_q;
        end else begin
            mem_addr = pc_q;
        end
    end

    // Next-state: redirect beats stall beats normal advance (reset is in the flop block).
    always_comb begin
        pc_d             = pc_q;
        fetch_pc_d       = fetch_pc_q;
        fetch_valid_d    = fetch_valid_q;
        if_id_inst_d     = if_id_inst_q;
        if_id_pc_plus1_d = if_id_pc_plus1_q;
        if_id_valid_d    = if_id_valid_q;
        fetch_count_d    = fetch_count_q;
        stall_count_d    = stall_count_q;
        if (redirect_valid) begin
            // Squash whatever is on mem_inst; link value in IF/ID is left as is.
            fetch_pc_d    = redirect_pc;
            fetch_valid_d = 1'b1;
            pc_d          = redirect_pc + ONE;
            if_id_inst_d  = '0;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            fetch_pc_d       = pc_q;
            fetch_valid_d    = 1'b1;
            pc_d             = pc_q + ONE;
            if_id_inst_d     = fetch_valid_q ? mem_inst : '0;
            if_id_pc_plus1_d = fetch_pc_q + ONE;
            if_id_valid_d    = fetch_valid_q;
            fetch_count_d    = fetch_count_q + 32'(fetch_valid_q);
        end
    end

    // State registers with synchronous reset that overrides stall and redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q             <= RST_PC;
            fetch_pc_q       <= RST_PC;
            fetch_valid_q    <= 1'b0;
            if_id_inst_q     <= '0;
            if_id_pc_plus1_q <= '0;
            if_id_valid_q    <= 1'b0;
            fetch_count_q    <= '0;
            stall_count_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            fetch_pc_q       <= fetch_pc_d;
            fetch_valid_q    <= fetch_valid_d;
            if_id_inst_q     <= if_id_inst_d;
            if_id_pc_plus1_q <= if_id_pc_plus1_d;
            if_id_valid_q    <= if_id_valid_d;
            fetch_count_q    <= fetch_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign if_id_inst     = if_id_inst_q;
    assign if_id_pc_plus1 = if_id_pc_plus1_q;
    assign if_id_valid    = if_id_valid_q;
    assign fetch_count    = fetch_count_q;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes expected IF/ID entries
// {inst, pc_plus1} into exp_q; a monitor pops one entry per newly delivered
// valid IF/ID slot and checks held/NOP slots in between.
module tb_fetch_unit;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_inst;
    logic [DW-1:0] if_id_inst;
    logic [AW-1:0] if_id_pc_plus1;
    logic          if_id_valid;
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 0;

    logic [DW+AW-1:0] exp_q[$];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory word at address a is a recognisable tag plus the address.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {21'd0, a};
    endfunction

    // Synchronous-read instruction memory model
    always @(posedge clock) mem_inst <= word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [AW-1:0] plus1);
        exp_q.push_back({word(a), plus1});
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Monitor / scoreboard
    initial begin
        bit hold_edge;
        logic [DW+AW-1:0] last_exp;
        logic [DW+AW-1:0] e;
        last_exp = '0;
        forever begin
            @(posedge clock);
            hold_edge = stall && !redirect_valid && !reset;
            @(negedge clock);
            if (done) break;
            if (!if_id_valid) begin
                chk("nop_inst", if_id_inst, 32'd0);
            end else if (hold_edge) begin
                chk("hold_inst", if_id_inst, last_exp[DW+AW-1:AW]);
                chk("hold_pc1", 32'(if_id_pc_plus1), 32'(last_exp[AW-1:0]));
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got inst %h pc1 %0d, expected none", if_id_inst,
                         if_id_pc_plus1);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                chk("if_id_inst", if_id_inst, e[DW+AW-1:AW]);
                chk("if_id_pc1", 32'(if_id_pc_plus1), 32'(e[AW-1:0]));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    // Driver / directed stimulus
    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        cyc();
        cyc();
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_scnt", stall_count, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);

        // Straight-line fetch of words 0..4
        push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(4, 5);
        reset = 1'b0;
        cyc();
        chk("first_edge_invalid", 32'(if_id_valid), 32'd0);
        cyc();
        cyc();
        chk("fcnt_2", fetch_count, 32'd2);

        // Three-cycle stall while IF/ID holds word 1
        stall = 1'b1;
        #1 chk("stall_addr", 32'(mem_addr), 32'd2);
        repeat (3) begin
            cyc();
            chk("stall_addr_hold", 32'(mem_addr), 32'd2);
        end
        chk("scnt_3", stall_count, 32'd3);
        chk("stall_valid", 32'(if_id_valid), 32'd1);
        stall = 1'b0;
        cyc();
        chk("fcnt_3", fetch_count, 32'd3);
        cyc();
        cyc();

        // Redirect to 15 while fetching 6
        chk("pre_redir_addr", 32'(mem_addr), 32'd6);
        push(15, 16); push(16, 17);
        redirect_valid = 1'b1;
        redirect_pc = 11'd15;
        #1 chk("redir_addr", 32'(mem_addr), 32'd15);
        cyc();
        redirect_valid = 1'b0;
        chk("redir_squash", 32'(if_id_valid), 32'd0);
        chk("redir_pc1_hold", 32'(if_id_pc_plus1), 32'd5);
        chk("redir_fcnt", fetch_count, 32'd5);
        cyc();
        cyc();

        // Stall and redirect together: redirect wins
        push(160, 161);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 11'd160;
        #1 chk("both_addr", 32'(mem_addr), 32'd160);
        cyc();
        stall = 1'b0;
        redirect_valid = 1'b0;
        chk("both_scnt", stall_count, 32'd3);
        chk("both_squash", 32'(if_id_valid), 32'd0);
        cyc();

        // Wrap at the top of the address space
        push(2046, 2047); push(2047, 0); push(0, 1);
        redirect_valid = 1'b1;
        redirect_pc = 11'd2046;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("fcnt_11", fetch_count, 32'd11);

        // Reset during a stall with IF/ID valid
        stall = 1'b1;
        #1 chk("stall2_addr", 32'(mem_addr), 32'd1);
        cyc();
        chk("scnt_4", stall_count, 32'd4);
        reset = 1'b1;
        #1 chk("rst2_addr", 32'(mem_addr), 32'd0);
        cyc();
        reset = 1'b0;
        stall = 1'b0;
        chk("rst2_valid", 32'(if_id_valid), 32'd0);
        chk("rst2_inst", if_id_inst, 32'd0);
        chk("rst2_pc1", 32'(if_id_pc_plus1), 32'd0);
        chk("rst2_fcnt", fetch_count, 32'd0);
        chk("rst2_scnt", stall_count, 32'd0);
        push(0, 1);
        cyc();
        cyc();
        chk("restart_fcnt", fetch_count, 32'd1);
        stall = 1'b1;
        cyc();
        done = 1'b1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
